// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: default width,
// FSM state encoding and bit-counter sizing.
package serial_add_sub_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One extra bit so the counter can represent WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_add_sub_full_adder.sv
// Single-bit full adder; the serial datapath reuses one instance every cycle.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract, one bit per clock LSB first; subtraction is
// performed as a + ~b + ~Cin so a single full adder serves both modes.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             c_out,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_sh_q, b_sh_q, s_sh_q, s_q;
    logic               carry_q, c_out_q, ovf_q;
    logic               fa_sum, fa_cout;
    logic               last_bit;

    full_adder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand shifters need no reset: they are always loaded at capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            s_sh_q  <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= mode ? ~b : b;
                        carry_q <= mode ? ~Cin : Cin;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    s_sh_q  <= {fa_sum, s_sh_q[WIDTH-1:1]};
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    // Visible result only moves on completion, so S holds
                    // steady while a following operation is shifting.
                    if (last_bit) begin
                        s_q     <= {fa_sum, s_sh_q[WIDTH-1:1]};
                        c_out_q <= fa_cout;
                        ovf_q   <= carry_q ^ fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign S     = s_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed self-checking bench for serial_add_sub at WIDTH=4.
module tb_serial_add_sub;

    logic       clk = 1'b0;
    logic       rst, start, mode, Cin;
    logic [3:0] a, b, S;
    logic       c_out, ovf, busy, done;

    int checks   = 0;
    int failures = 0;

    serial_add_sub #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .a     (a),
        .b     (b),
        .Cin   (Cin),
        .S     (S),
        .c_out (c_out),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Launch one operation and wait (bounded) for done; lat counts falling
    // edges after the capture edge, 0 if done never arrived.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v,
                          input logic tm, input logic tc, output int lat);
        @(negedge clk);
        a = ta; b = tb_v; mode = tm; Cin = tc; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int n_done;
        int t1, t2;
        logic hold_ok;
        logic [3:0] s_at_done;

        rst = 1'b1; start = 1'b0; mode = 1'b0; Cin = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_S", S, 4'h0);
        chk("rst_cout", c_out, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;

        // 7 + (-8)
        run_op(4'b0111, 4'b1000, 1'b0, 1'b0, lat);
        chk("add1_lat", lat, 5);
        chk("add1_S", S, 4'b1111);
        chk("add1_cout", c_out, 1'b0);
        chk("add1_ovf", ovf, 1'b0);
        @(negedge clk);
        chk("add1_done_pulse", done, 1'b0);
        repeat (2) @(negedge clk);
        chk("add1_hold_S", S, 4'b1111);
        chk("idle_busy", busy, 1'b0);

        run_op(4'b0111, 4'b1010, 1'b0, 1'b0, lat);
        chk("add2_S", S, 4'b0001);
        chk("add2_cout", c_out, 1'b1);
        chk("add2_ovf", ovf, 1'b0);

        run_op(4'b0100, 4'b0110, 1'b0, 1'b0, lat);
        chk("add3_S", S, 4'b1010);
        chk("add3_cout", c_out, 1'b0);
        chk("add3_ovf", ovf, 1'b1);

        run_op(4'b0100, 4'b0110, 1'b1, 1'b0, lat);
        chk("sub1_S", S, 4'b1110);
        chk("sub1_cout", c_out, 1'b0);
        chk("sub1_ovf", ovf, 1'b0);

        run_op(4'b0111, 4'b1000, 1'b1, 1'b0, lat);
        chk("sub2_S", S, 4'b1111);
        chk("sub2_cout", c_out, 1'b0);
        chk("sub2_ovf", ovf, 1'b1);

        // 5 - 2 - 1 with borrow-in: no borrow out
        run_op(4'b0101, 4'b0010, 1'b1, 1'b1, lat);
        chk("sub3_S", S, 4'b0010);
        chk("sub3_cout", c_out, 1'b1);

        // Busy rejection: second start lands in SHIFT cycle 2
        @(negedge clk);
        a = 4'b0111; b = 4'b1000; mode = 1'b0; Cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_done = 0; s_at_done = '0; lat = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 2) begin
                a = 4'b1001; b = 4'b0001; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    lat = i;
                    s_at_done = S;
                end
            end
        end
        chk("busy_rej_ndone", n_done, 1);
        chk("busy_rej_lat", lat, 5);
        chk("busy_rej_S", s_at_done, 4'b1111);

        // Reset during SHIFT cycle 2
        @(negedge clk);
        a = 4'b0100; b = 4'b0110; mode = 1'b0; Cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midop_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_S", S, 4'h0);
        chk("midrst_cout", c_out, 1'b0);
        chk("midrst_ovf", ovf, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("midrst_no_done", n_done, 0);
        run_op(4'b1001, 4'b0001, 1'b0, 1'b0, lat);
        chk("post_rst_lat", lat, 5);
        chk("post_rst_S", S, 4'b1010);
        chk("post_rst_cout", c_out, 1'b0);
        chk("post_rst_ovf", ovf, 1'b0);

        // Back-to-back with start held high
        @(negedge clk);
        a = 4'b0011; b = 4'b0001; mode = 1'b0; Cin = 1'b0; start = 1'b1;
        t1 = -1; t2 = -1; hold_ok = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (done) begin
                if (t1 < 0) begin
                    t1 = i;
                    chk("b2b_S1", S, 4'b0100);
                    a = 4'b0101;
                end else begin
                    t2 = i;
                    chk("b2b_S2", S, 4'b0110);
                    start = 1'b0;
                    break;
                end
            end else if (t1 >= 0 && S !== 4'b0100) begin
                hold_ok = 1'b0;
            end
        end
        start = 1'b0;
        chk("b2b_spacing", t2 - t1, 6);
        chk("b2b_hold", hold_ok, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
